bit_shift_left16: RTL and testbench
===================================

# bit_shift_left16

Registered 16-bit logical left shifter: operand `a` is shifted left by the unsigned amount in `b`, zero-filled, and the result is registered on the next clock edge. It is the shift primitive of the ML accelerator datapath, used for power-of-two scaling of fixed-point values ahead of the MAC/accumulate stages.

## Interface
- Parameters: none; widths come from the shared package (data 16 bits, shift amount 16 bits).
- Clocking: one clock; reset is synchronous and active-high.
- `clk`  input  1  sole clock; all state updates on its rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `in_valid`  input  1  qualifies `a`/`b` in the current cycle.
- `a`  input  16  operand to shift, treated as an unsigned bit vector.
- `b`  input  16  shift amount, unsigned.
- `out_valid`  output  1  `out` holds the result of a qualified input.
- `out`  output  16  registered result `a << b`.
- `ovf`  output  1  present only with `BIT_SHIFT_LEFT16_OVF_EN`; at least one `1` bit was shifted out.

## Operation
- Logical left shift with zero fill into the LSBs. No sign handling and no rotation.
- Shift amounts 0..15: `out = (a << b)[15:0]`.
- Shift amounts ≥ 16 (any of `b[15:4]` nonzero): `out = 16'h0000`.
- `b = 0`: `out = a`.
- Core is a 4-stage combinational barrel shifter controlled by `b[3:0]`. Stage k shifts by 2^k when `b[k]` is set.
- A range-check forces a zero result when `b[15:4]` is nonzero.
- Overflow flag (when compiled in): `ovf = 1` iff any `1` bit of `a` is discarded.
  - For `b` ≥ 16, `ovf = |a`.
  - Otherwise `ovf = |(a & ~(16'hFFFF >> b))`.
- When `in_valid = 0`: `out` and `ovf` hold their previous values and `out_valid` drops to 0.

## Timing
- Latency: 1 cycle. Inputs sampled at rising edge N appear on `out`/`out_valid`/`ovf` after edge N.
- Throughput: one operation per cycle. No backpressure and no stall input.
- Reset (`rst` high at a rising edge) sets `out = 16'h0000`, `out_valid = 0`, `ovf = 0`.
- Reset has priority over `in_valid` in the same cycle, so an in-flight operation is discarded.
- First valid result can appear one cycle after the first edge with `rst = 0` and `in_valid = 1`.
- Outputs are driven purely from registers. There is no combinational path from inputs to outputs.

## Configuration
- Macro: `BIT_SHIFT_LEFT16_OVF_EN`.
- Defined: `ovf` port and register exist, with behaviour as above.
- Undefined: no `ovf` port or logic. All other behaviour is identical.

## Structure
- Shared package `bit_shift_pkg` holds:
  - `DATA_W = 16`
  - `SHAMT_W = 16`
  - `STAGES = 4`
  - typedefs `data_t` (logic [15:0]) and `shamt_t` (logic [15:0]).
- One sub-module, `bsl16_barrel`: purely combinational 4-stage barrel shifter with range-check zeroing and optional overflow detection.
- The top level instantiates `bsl16_barrel` and adds the output registers and the valid pipeline.

## Test plan
- Reset: assert `rst` with `in_valid = 1`, `a = 16'hFFFF`, `b = 1` → next cycle `out = 16'h0000`, `out_valid = 0`, `ovf = 0`.
- Basic shifts, one cycle later each:
  - `a = 0`, `b = 0` → `out = 16'h0000`.
  - `a = 1`, `b = 1` → `out = 16'h0002`.
  - `a = 1`, `b = 2` → `out = 16'h0004`.
- Top bit: `a = 1`, `b = 15` → `out = 16'h8000`, `ovf = 0`. Then `a = 1`, `b = 16` → `out = 16'h0000`, `ovf = 1`.
- Out-of-range: `a = 16'h1234`, `b = 16'h0100` → `out = 16'h0000`, `ovf = 1`. Also `a = 16'h1234`, `b = 0` → `out = 16'h1234`.
- Overflow: `a = 16'hFFFF`, `b = 4` → `out = 16'hFFF0`, `ovf = 1`. Then `a = 16'h0FFF`, `b = 4` → `out = 16'hFFF0`, `ovf = 0`.
- Hold/throughput:
  - Back-to-back valid inputs `b = 0..15` with `a = 1` → `out` walks `16'h0001..16'h8000` one per cycle.
  - Then `in_valid = 0` → `out` holds `16'h8000` and `out_valid = 0`.

Source files
------------

// File: rtl/bit_shift_pkg.sv
// -----------------------------------------------------------------------------
// bit_shift_pkg
// Shared widths and types for the 16-bit left-shift primitive.
//   DATA_W  : operand/result width
//   SHAMT_W : shift-amount width
//   STAGES  : barrel stages; the low STAGES bits of the shift amount drive the
//             barrel, anything above them is an out-of-range shift.
// -----------------------------------------------------------------------------
package bit_shift_pkg;

  localparam int DATA_W  = 16;
  localparam int SHAMT_W = 16;
  localparam int STAGES  = 4;

  typedef logic [DATA_W-1:0]  data_t;
  typedef logic [SHAMT_W-1:0] shamt_t;

  // True when the shift amount can be realised by the barrel (0..DATA_W-1).
  function automatic logic shamt_in_range(input logic [SHAMT_W-1:0] s);
    return (s[SHAMT_W-1:STAGES] == '0);
  endfunction

endpackage

// File: rtl/bsl16_barrel.sv
// -----------------------------------------------------------------------------
// bsl16_barrel
// Purely combinational 4-stage logical left barrel shifter, zero fill.
// Stage k shifts by 2^k when i_b[k] is set. Shift amounts with any of the
// upper bits set force a zero result.
// Optional overflow detection is compiled in with BIT_SHIFT_LEFT16_OVF_EN.
// Ports:
//   i_a   in  16  operand
//   i_b   in  16  unsigned shift amount
//   o_res out 16  shifted result
//   o_ovf out  1  a '1' bit of i_a was discarded (BIT_SHIFT_LEFT16_OVF_EN only)
// -----------------------------------------------------------------------------
module bsl16_barrel
  import bit_shift_pkg::*;
(
  input  logic [DATA_W-1:0]  i_a,
  input  logic [SHAMT_W-1:0] i_b,
`ifdef BIT_SHIFT_LEFT16_OVF_EN
  output logic               o_ovf,
`endif
  output logic [DATA_W-1:0]  o_res
);

  // w_stage[k] is the value entering stage k; w_stage[STAGES] is the barrel output.
  logic [DATA_W-1:0] w_stage [0:STAGES];
  logic              w_in_range;

`ifdef BIT_SHIFT_LEFT16_OVF_EN
  // w_lost[k]: stage k pushed at least one '1' out of the top of the word.
  logic [STAGES-1:0] w_lost;
`endif

  assign w_stage[0] = i_a;

  genvar k;
  for (k = 0; k < STAGES; k++) begin : g_stage
    localparam int SH = 1 << k;

    assign w_stage[k+1] = i_b[k] ? (w_stage[k] << SH) : w_stage[k];

`ifdef BIT_SHIFT_LEFT16_OVF_EN
    // The SH bits at the top of this stage's input are the ones that fall off.
    // Each discarded bit leaves the word in exactly one stage, so OR-ing the
    // per-stage losses covers every discarded bit of the original operand.
    assign w_lost[k] = i_b[k] & (|w_stage[k][DATA_W-1 -: SH]);
`endif
  end

  assign w_in_range = shamt_in_range(i_b);
  assign o_res      = w_in_range ? w_stage[STAGES] : '0;

`ifdef BIT_SHIFT_LEFT16_OVF_EN
  // Out-of-range shifts discard the whole operand.
  assign o_ovf = w_in_range ? (|w_lost) : (|i_a);
`endif

endmodule

// File: rtl/bit_shift_left16.sv
// -----------------------------------------------------------------------------
// bit_shift_left16
// Registered 16-bit logical left shifter: out = a << b (zero fill), with
// shift amounts >= 16 giving zero. One cycle latency, one op per cycle, no
// backpressure. Outputs come straight from registers.
// Optional feature macro: BIT_SHIFT_LEFT16_OVF_EN adds the ovf port/register.
// Ports:
//   clk       in   1  clock, rising edge
//   rst       in   1  synchronous active-high reset
//   in_valid  in   1  qualifies a/b this cycle
//   a         in  16  operand
//   b         in  16  unsigned shift amount
//   out_valid out  1  out holds the result of a qualified input
//   out       out 16  registered result
//   ovf       out  1  a '1' bit was shifted out (BIT_SHIFT_LEFT16_OVF_EN only)
// Handshake: in_valid is a one-way strobe; every qualified input produces
// exactly one out_valid pulse one cycle later. There is no ready signal.
// When in_valid is low, out/ovf hold and out_valid drops.
// -----------------------------------------------------------------------------
module bit_shift_left16
  import bit_shift_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  a,
  input  logic [SHAMT_W-1:0] b,
  output logic               out_valid,
`ifdef BIT_SHIFT_LEFT16_OVF_EN
  output logic               ovf,
`endif
  output logic [DATA_W-1:0]  out
);

  logic [DATA_W-1:0] w_res;
  logic [DATA_W-1:0] r_out;
  logic              r_out_valid;

`ifdef BIT_SHIFT_LEFT16_OVF_EN
  logic w_ovf;
  logic r_ovf;
`endif

  bsl16_barrel u_barrel (
    .i_a   (a),
    .i_b   (b),
`ifdef BIT_SHIFT_LEFT16_OVF_EN
    .o_ovf (w_ovf),
`endif
    .o_res (w_res)
  );

  // Reset wins over in_valid, so an operation presented during reset is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
`ifdef BIT_SHIFT_LEFT16_OVF_EN
      r_ovf       <= 1'b0;
`endif
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_out <= w_res;
`ifdef BIT_SHIFT_LEFT16_OVF_EN
        r_ovf <= w_ovf;
`endif
      end
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;
`ifdef BIT_SHIFT_LEFT16_OVF_EN
  assign ovf       = r_ovf;
`endif

endmodule

// File: tb/tb_bit_shift_left16.sv
module tb_bit_shift_left16;
  import bit_shift_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic [15:0] out;
`ifdef BIT_SHIFT_LEFT16_OVF_EN
  logic        ovf;
`endif

  always #5 clk = ~clk;

  bit_shift_left16 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
`ifdef BIT_SHIFT_LEFT16_OVF_EN
    .ovf       (ovf),
`endif
    .out       (out)
  );

  // ---------------- scoreboard ----------------
  // Entry layout: {ovf, out}
  logic [16:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [16:0] model(input logic [15:0] aa, input logic [15:0] bb);
    logic [15:0] o;
    logic        f;
    if (bb > 16'd15) begin
      o = 16'h0000;
      f = |aa;
    end else begin
      o = aa << bb;
      f = |(aa & ~(16'hFFFF >> bb));
    end
    return {f, o};
  endfunction

  // ---------------- driver ----------------
  // Called just after a rising edge; the inputs are taken at the next edge.
  task automatic drive(input logic v, input logic [15:0] aa, input logic [15:0] bb);
    in_valid = v;
    a        = aa;
    b        = bb;
    if (v) exp_q.push_back(model(aa, bb));
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; a = 16'hFFFF; b = 16'd1;
    @(posedge clk); #1;
    checks++;
    if (out !== 16'h0000) begin errors++; $display("FAIL reset_out got %h want 0000", out); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
`ifdef BIT_SHIFT_LEFT16_OVF_EN
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
`endif
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_table(input string name, input logic [15:0] ta[], input logic [15:0] tb[]);
    logic [16:0] exp;
    for (int i = 0; i < ta.size(); i++) begin
      drive(1'b1, ta[i], tb[i]);
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1) begin
        errors++; $display("FAIL %s_valid[%0d] got %b want 1", name, i, out_valid);
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL %s_queue[%0d] empty", name, i);
      end else begin
        exp = exp_q.pop_front();
        if (out !== exp[15:0]) begin
          errors++;
          $display("FAIL %s_out[%0d] a=%h b=%h got %h want %h", name, i, ta[i], tb[i], out, exp[15:0]);
        end
`ifdef BIT_SHIFT_LEFT16_OVF_EN
        checks++;
        if (ovf !== exp[16]) begin
          errors++;
          $display("FAIL %s_ovf[%0d] a=%h b=%h got %b want %b", name, i, ta[i], tb[i], ovf, exp[16]);
        end
`endif
      end
    end
  endtask

  task automatic test_basic();
    logic [15:0] ta[] = '{16'h0000, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h1234, 16'h1234};
    logic [15:0] tb[] = '{16'd0,    16'd1,    16'd2,    16'd15,   16'd16,   16'h0100, 16'd0};
    test_table("basic", ta, tb);
  endtask

  task automatic test_overflow();
    logic [15:0] ta[] = '{16'hFFFF, 16'h0FFF, 16'h8000, 16'h4000, 16'hABCD, 16'h0000};
    logic [15:0] tb[] = '{16'd4,    16'd4,    16'd1,    16'd1,    16'hFFFF, 16'h8000};
    test_table("ovf", ta, tb);
  endtask

  task automatic test_back_to_back();
    logic [16:0] exp;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 16'h0001, 16'(i));
      @(posedge clk); #1;
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL b2b_queue[%0d] empty", i);
      end else begin
        exp = exp_q.pop_front();
        if (out_valid !== 1'b1 || out !== exp[15:0]) begin
          errors++;
          $display("FAIL b2b[%0d] got v=%b out=%h want v=1 out=%h", i, out_valid, out, exp[15:0]);
        end
      end
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 16'($urandom_range(0, 16'hFFFF)), 16'($urandom_range(0, 3)));
      @(posedge clk); #1;
      checks++;
      if (out !== 16'h8000 || out_valid !== 1'b0) begin
        errors++; $display("FAIL hold[%0d] got v=%b out=%h want v=0 out=8000", i, out_valid, out);
      end
`ifdef BIT_SHIFT_LEFT16_OVF_EN
      checks++;
      if (ovf !== 1'b0) begin errors++; $display("FAIL hold_ovf[%0d] got %b want 0", i, ovf); end
`endif
    end
  endtask

  task automatic test_random();
    logic [15:0] ta[];
    logic [15:0] tb[];
    ta = new[40];
    tb = new[40];
    for (int i = 0; i < 40; i++) begin
      ta[i] = 16'($urandom_range(0, 16'hFFFF));
      tb[i] = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(16, 16'hFFFF))
                                          : 16'($urandom_range(0, 15));
    end
    test_table("rand", ta, tb);
  endtask

  task automatic test_reset_priority();
    logic [15:0] ta[] = '{16'h0001};
    logic [15:0] tb[] = '{16'd3};
    test_table("pre_rst", ta, tb);
    rst = 1'b1; in_valid = 1'b1; a = 16'hFFFF; b = 16'd1;
    @(posedge clk); #1;
    checks++;
    if (out !== 16'h0000 || out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_prio got v=%b out=%h want v=0 out=0000", out_valid, out);
    end
`ifdef BIT_SHIFT_LEFT16_OVF_EN
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("FAIL rst_prio_ovf got %b want 0", ovf); end
`endif
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_overflow();
    test_back_to_back();
    test_hold();
    test_random();
    test_reset_priority();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL leftover_queue got %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
